// File: rtl/lc3b_types.sv
// Shared LC-3b pipeline types: register index, hazard sequencer states, NOP bubble encoding.
package lc3b_types;

  typedef logic [2:0]  lc3b_reg;
  typedef logic [15:0] lc3b_word;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    IND   = 2'd1,
    REDIR = 2'd2
  } lc3b_hazard_state;

  // BR with nzp = 000 never branches, so all-zero is a harmless bubble.
  localparam lc3b_word lc3b_nop = 16'h0000;

  // Stage-enable vector order: {pc, if_id, id_ex, ex_mem, mem_wb}.
  localparam logic [4:0] LdNone   = 5'b00000;
  localparam logic [4:0] LdAll    = 5'b11111;
  localparam logic [4:0] LdBubble = 5'b00111;

  // Flush vector order: {if_id, id_ex, ex_mem}.
  localparam logic [2:0] FlNone   = 3'b000;
  localparam logic [2:0] FlAll    = 3'b111;
  localparam logic [2:0] FlBubble = 3'b010;

endpackage

// File: rtl/hazard_perf_counters.sv
// Saturating stall/flush event counters for the hazard sequencer.
module hazard_perf_counters #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mem_stall_i,
  input  logic                 lu_bubble_i,
  input  logic                 redirect_i,
  output logic [CNT_WIDTH-1:0] stall_mem_cnt_o,
  output logic [CNT_WIDTH-1:0] stall_lu_cnt_o,
  output logic [CNT_WIDTH-1:0] flush_cnt_o
);

  logic [CNT_WIDTH-1:0] mem_q, mem_d;
  logic [CNT_WIDTH-1:0] lu_q, lu_d;
  logic [CNT_WIDTH-1:0] fl_q, fl_d;

  always_comb begin
    mem_d = mem_q;
    lu_d  = lu_q;
    fl_d  = fl_q;
    if (mem_stall_i && (mem_q != '1)) mem_d = mem_q + 1'b1;
    if (lu_bubble_i && (lu_q != '1))  lu_d  = lu_q + 1'b1;
    if (redirect_i && (fl_q != '1))   fl_d  = fl_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
      lu_q  <= '0;
      fl_q  <= '0;
    end else begin
      mem_q <= mem_d;
      lu_q  <= lu_d;
      fl_q  <= fl_d;
    end
  end

  assign stall_mem_cnt_o = mem_q;
  assign stall_lu_cnt_o  = lu_q;
  assign flush_cnt_o     = fl_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage LC-3b pipeline.
// Define HAZARD_PERF_CNT_EN to add saturating stall/flush performance counters.
module pipeline_hazard_ctrl
  import lc3b_types::*;
`ifdef HAZARD_PERF_CNT_EN
#(
  parameter int unsigned CNT_WIDTH = 16
)
`endif
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             imem_read,
  input  logic             imem_resp,
  input  logic             dmem_req,
  input  logic             dmem_resp,
  input  logic             mem_indirect,
  input  logic             mem_br_taken,
  input  logic             exec_mem_read,
  input  logic             exec_reg_write,
  input  lc3b_reg          exec_dest,
  input  lc3b_reg          id_sr1,
  input  lc3b_reg          id_sr2,
  input  logic             id_uses_sr2,
  output logic             load_pc,
  output logic             load_if_id,
  output logic             load_id_ex,
  output logic             load_ex_mem,
  output logic             load_mem_wb,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             flush_ex_mem,
  output logic             indirect_phase,
`ifdef HAZARD_PERF_CNT_EN
  output logic [CNT_WIDTH-1:0] stall_mem_cnt,
  output logic [CNT_WIDTH-1:0] stall_lu_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt,
`endif
  output lc3b_hazard_state ctrl_state
);

  lc3b_hazard_state state_q, state_d;
  logic [4:0] ld;
  logic [2:0] fl;
  logic       mem_wait;
  logic       load_use;
  logic       redirect;
  logic       lu_bubble;

  assign mem_wait = (imem_read & ~imem_resp) | (dmem_req & ~dmem_resp);
  assign load_use = exec_mem_read & exec_reg_write &
                    ((exec_dest == id_sr1) | (id_uses_sr2 & (exec_dest == id_sr2)));

  always_comb begin
    ld        = LdNone;
    fl        = FlNone;
    state_d   = state_q;
    redirect  = 1'b0;
    lu_bubble = 1'b0;
    if (!rst_n) begin
      // Reset holds every stage register on a bubble without advancing.
      fl      = FlAll;
      state_d = RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (!mem_wait) begin
            if (mem_br_taken) begin
              ld       = LdAll;
              fl       = FlAll;
              state_d  = REDIR;
              redirect = 1'b1;
            end else if (mem_indirect && dmem_resp) begin
              state_d = IND;
            end else if (load_use) begin
              ld        = LdBubble;
              fl        = FlBubble;
              lu_bubble = 1'b1;
            end else begin
              ld = LdAll;
            end
          end
        end
        IND: begin
          if (!mem_wait && dmem_resp) begin
            ld      = LdAll;
            state_d = RUN;
          end
        end
        REDIR: begin
          // ID and MEM both hold bubbles here, so neither hazard can be real.
          if (!mem_wait) begin
            ld      = LdAll;
            state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  assign {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb} = ld;
  assign {flush_if_id, flush_id_ex, flush_ex_mem}                    = fl;
  assign indirect_phase = (state_q == IND);
  assign ctrl_state     = state_q;

`ifdef HAZARD_PERF_CNT_EN
  hazard_perf_counters #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_perf (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_stall_i    (mem_wait & rst_n),
    .lu_bubble_i    (lu_bubble),
    .redirect_i     (redirect),
    .stall_mem_cnt_o(stall_mem_cnt),
    .stall_lu_cnt_o (stall_lu_cnt),
    .flush_cnt_o    (flush_cnt)
  );
`else
  logic unused_lu;
  assign unused_lu = lu_bubble ^ redirect;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with hand-computed expected enables/flushes/state.
module tb_pipeline_hazard_ctrl;
  import lc3b_types::*;

  logic clk = 1'b0;
  logic rst_n;
  logic imem_read, imem_resp, dmem_req, dmem_resp, mem_indirect, mem_br_taken;
  logic exec_mem_read, exec_reg_write, id_uses_sr2;
  lc3b_reg exec_dest, id_sr1, id_sr2;
  logic load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
  logic flush_if_id, flush_id_ex, flush_ex_mem, indirect_phase;
  lc3b_hazard_state ctrl_state;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_mem_cnt, stall_lu_cnt, flush_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_read     (imem_read),
    .imem_resp     (imem_resp),
    .dmem_req      (dmem_req),
    .dmem_resp     (dmem_resp),
    .mem_indirect  (mem_indirect),
    .mem_br_taken  (mem_br_taken),
    .exec_mem_read (exec_mem_read),
    .exec_reg_write(exec_reg_write),
    .exec_dest     (exec_dest),
    .id_sr1        (id_sr1),
    .id_sr2        (id_sr2),
    .id_uses_sr2   (id_uses_sr2),
    .load_pc       (load_pc),
    .load_if_id    (load_if_id),
    .load_id_ex    (load_id_ex),
    .load_ex_mem   (load_ex_mem),
    .load_mem_wb   (load_mem_wb),
    .flush_if_id   (flush_if_id),
    .flush_id_ex   (flush_id_ex),
    .flush_ex_mem  (flush_ex_mem),
    .indirect_phase(indirect_phase),
`ifdef HAZARD_PERF_CNT_EN
    .stall_mem_cnt (stall_mem_cnt),
    .stall_lu_cnt  (stall_lu_cnt),
    .flush_cnt     (flush_cnt),
`endif
    .ctrl_state    (ctrl_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic expect_ctrl(input string tag, input logic [4:0] ld, input logic [2:0] fl,
                             input lc3b_hazard_state st, input logic ph);
    check({tag, ".loads"}, 32'({load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb}),
          32'(ld));
    check({tag, ".flush"}, 32'({flush_if_id, flush_id_ex, flush_ex_mem}), 32'(fl));
    check({tag, ".state"}, 32'(ctrl_state), 32'(st));
    check({tag, ".phase"}, 32'(indirect_phase), 32'(ph));
  endtask

  // Advance one edge, then let inputs change away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    imem_read = 0; imem_resp = 0; dmem_req = 0; dmem_resp = 0;
    mem_indirect = 0; mem_br_taken = 0;
    exec_mem_read = 0; exec_reg_write = 0; id_uses_sr2 = 0;
    exec_dest = 3'd0; id_sr1 = 3'd1; id_sr2 = 3'd1;
  endtask

  task automatic set_lu(input lc3b_reg dst, input lc3b_reg s1, input lc3b_reg s2,
                        input logic use2);
    exec_mem_read = 1; exec_reg_write = 1;
    exec_dest = dst; id_sr1 = s1; id_sr2 = s2; id_uses_sr2 = use2;
  endtask

  initial begin
    rst_n = 0;
    clear_inputs();
    step();
    #1 expect_ctrl("reset", 5'b00000, 3'b111, RUN, 1'b0);
    rst_n = 1;
    #1 expect_ctrl("release", 5'b11111, 3'b000, RUN, 1'b0);
    step();

    // LDR R2 in EX, ADD R3,R2,R1 in ID.
    set_lu(3'd2, 3'd2, 3'd1, 1'b1);
    #1 expect_ctrl("lu_sr1", 5'b00111, 3'b010, RUN, 1'b0);
    step();
    clear_inputs();
    #1 expect_ctrl("lu_after", 5'b11111, 3'b000, RUN, 1'b0);

    set_lu(3'd2, 3'd4, 3'd2, 1'b0);
    #1 expect_ctrl("lu_false_pos", 5'b11111, 3'b000, RUN, 1'b0);
    set_lu(3'd2, 3'd4, 3'd2, 1'b1);
    #1 expect_ctrl("lu_sr2", 5'b00111, 3'b010, RUN, 1'b0);
    exec_reg_write = 0;
    #1 expect_ctrl("lu_no_wr", 5'b11111, 3'b000, RUN, 1'b0);
    step();
    clear_inputs();

    // D-cache miss for 5 cycles.
    dmem_req = 1;
    for (int i = 0; i < 5; i++) begin
      #1 expect_ctrl($sformatf("dmiss%0d", i), 5'b00000, 3'b000, RUN, 1'b0);
      step();
    end
    dmem_resp = 1;
    #1 expect_ctrl("dmiss_resp", 5'b11111, 3'b000, RUN, 1'b0);
    step();
    clear_inputs();

    // LDI: address access, then data access three cycles later.
    mem_indirect = 1; dmem_req = 1;
    #1 expect_ctrl("ldi_wait0", 5'b00000, 3'b000, RUN, 1'b0);
    step();
    dmem_resp = 1;
    #1 expect_ctrl("ldi_resp1", 5'b00000, 3'b000, RUN, 1'b0);
    step();
    dmem_resp = 0;
    #1 expect_ctrl("ldi_ind_a", 5'b00000, 3'b000, IND, 1'b1);
    step();
    #1 expect_ctrl("ldi_ind_b", 5'b00000, 3'b000, IND, 1'b1);
    step();
    dmem_resp = 1;
    #1 expect_ctrl("ldi_resp2", 5'b11111, 3'b000, IND, 1'b1);
    step();
    clear_inputs();
    #1 expect_ctrl("ldi_done", 5'b11111, 3'b000, RUN, 1'b0);

    // Redirect coincident with a load-use: redirect wins.
    mem_br_taken = 1;
    set_lu(3'd3, 3'd3, 3'd0, 1'b0);
    #1 expect_ctrl("redir_lu", 5'b11111, 3'b111, RUN, 1'b0);
    step();
    #1 expect_ctrl("redir_next", 5'b11111, 3'b000, REDIR, 1'b0);
    step();
    clear_inputs();
    #1 expect_ctrl("redir_back", 5'b11111, 3'b000, RUN, 1'b0);

    // Redirect deferred by an I-cache wait.
    mem_br_taken = 1; imem_read = 1;
    #1 expect_ctrl("redir_wait", 5'b00000, 3'b000, RUN, 1'b0);
    step();
    #1 expect_ctrl("redir_wait2", 5'b00000, 3'b000, RUN, 1'b0);
    imem_resp = 1;
    #1 expect_ctrl("redir_go", 5'b11111, 3'b111, RUN, 1'b0);
    step();
    mem_br_taken = 0; imem_resp = 0;
    #1 expect_ctrl("redir_hold", 5'b00000, 3'b000, REDIR, 1'b0);
    imem_resp = 1;
    step();
    clear_inputs();
    #1 expect_ctrl("redir_exit", 5'b11111, 3'b000, RUN, 1'b0);

    // Reset asserted while in IND.
    mem_indirect = 1; dmem_req = 1; dmem_resp = 1;
    step();
    dmem_resp = 0;
    #1 expect_ctrl("pre_rst_ind", 5'b00000, 3'b000, IND, 1'b1);
    rst_n = 0;
    #1 expect_ctrl("rst_mid", 5'b00000, 3'b111, RUN, 1'b0);
    step();
    clear_inputs();
    rst_n = 1;
    #1 expect_ctrl("rst_rel", 5'b11111, 3'b000, RUN, 1'b0);
    step();
    #1 expect_ctrl("rst_adv", 5'b11111, 3'b000, RUN, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage LC-3b pipeline (IF, ID, EX, MEM, WB).
- Drives the per-stage pipeline-register load enables and flush controls. Arbitrates four stall sources:
  - outstanding I-cache and D-cache accesses;
  - load-use hazards the forwarding logic cannot cover;
  - two-access indirect ops (LDI/STI);
  - control-flow redirects resolved in MEM.
- Sits beside the forwarding logic in the datapath top level.

Parameters:
- CNT_WIDTH, 16, width of the optional performance counters.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- imem_read  in  1  IF fetch request pending
- imem_resp  in  1  I-cache response this cycle
- dmem_req  in  1  MEM-stage read or write pending
- dmem_resp  in  1  D-cache response this cycle
- mem_indirect  in  1  MEM-stage op is LDI or STI
- mem_br_taken  in  1  BR/JMP/JSR/TRAP resolved taken in MEM
- exec_mem_read  in  1  EX-stage op is a load
- exec_reg_write  in  1  EX-stage op writes a register
- exec_dest  in  lc3b_reg  EX-stage destination register
- id_sr1  in  lc3b_reg  ID-stage source 1
- id_sr2  in  lc3b_reg  ID-stage source 2
- id_uses_sr2  in  1  ID op reads sr2 (not imm5 or offset form)
- load_pc  out  1  PC register enable
- load_if_id, load_id_ex, load_ex_mem, load_mem_wb  out  1 each  stage-register enables
- flush_if_id, flush_id_ex, flush_ex_mem  out  1 each  replace stage contents with NOP bubble on next edge
- indirect_phase  out  1  0 = address fetch, 1 = second (data) access of LDI/STI
- ctrl_state  out  lc3b_hazard_state  current FSM state, for debug

Behaviour:
- Reset: clk and rst_n only; asynchronous, active-low.
  - While rst_n = 0: state = RUN, indirect_phase = 0, all load_* = 0, all flush_* = 1, counters = 0.
  - Release takes effect on the first clk edge after rst_n rises.
- The FSM is registered. Outputs are combinational from state and inputs. Zero-cycle latency from stall source to enable.
- Memory wait:
  - Defined as (imem_read & ~imem_resp) | (dmem_req & ~dmem_resp).
  - Forces every load_* = 0 and every flush_* = 0.
  - FSM holds state. Highest priority after reset.
- States:
  - RUN: normal operation.
  - IND: second access of LDI/STI.
  - REDIR: one cycle after a redirect.
- RUN, with no memory wait, applies the first matching rule:
  1. mem_br_taken: load_pc = 1, all load_* = 1, flush_if_id = flush_id_ex = flush_ex_mem = 1; next state REDIR.
  2. mem_indirect & dmem_resp: all load_* = 0; next state IND.
  3. Load-use: exec_mem_read & exec_reg_write & (exec_dest == id_sr1 | (id_uses_sr2 & exec_dest == id_sr2)).
     - load_pc = load_if_id = 0; load_id_ex = 1 with flush_id_ex = 1 (bubble); load_ex_mem = load_mem_wb = 1.
     - Stay in RUN. The hazard clears the next cycle because the load has moved to MEM.
  4. Otherwise: all load_* = 1, flushes 0.
- IND:
  - indirect_phase = 1. All loads stay 0 until dmem_resp, then all loads = 1 and next state RUN.
  - A memory wait in IND keeps IND.
  - mem_br_taken cannot occur in IND and is ignored.
- REDIR:
  - Load-use detection is suppressed because ID holds a bubble.
  - All loads = 1 when there is no memory wait; next state RUN.
  - mem_br_taken in REDIR is ignored because MEM holds a bubble.
- Simultaneous events:
  - A redirect coincident with a load-use: redirect wins; the load-use instruction is squashed.
  - A redirect during a memory wait is deferred until the response arrives.
- An illegal state encoding returns to RUN on the next edge.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined, adds three outputs: stall_mem_cnt, stall_lu_cnt, flush_cnt, each CNT_WIDTH bits, saturating.
  - stall_mem_cnt increments on each memory-wait cycle.
  - stall_lu_cnt increments on each load-use bubble.
  - flush_cnt increments on each redirect.
  - All clear on rst_n.
- When undefined, these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- lc3b_types gains:
  - lc3b_hazard_state enum {RUN, IND, REDIR};
  - constant lc3b_nop for bubble encoding.
- One sub-module: hazard_perf_counters, instantiated only under HAZARD_PERF_CNT_EN.

Test Plan:
- Reset mid-stall: assert rst_n = 0 during IND → flushes = 1, loads = 0, state RUN immediately; after release, the first edge is a normal advance.
- Load-use: LDR R2 in EX, ADD R3,R2,R1 in ID → one cycle with load_pc = 0, load_if_id = 0, flush_id_ex = 1; next cycle all loads = 1.
- Load-use false positive: exec_dest = R2, id_sr2 = R2, id_uses_sr2 = 0, id_sr1 = R4 → no stall.
- D-cache miss: dmem_req = 1, dmem_resp = 0 for 5 cycles → all loads = 0 for 5 cycles; on resp, advance.
- LDI: mem_indirect = 1, two responses 3 cycles apart → indirect_phase 0 then 1, return to RUN after the second resp, exactly one advance.
- Redirect with a concurrent load-use hazard → flush_if_id, flush_id_ex, flush_ex_mem all 1 and load_pc = 1 in the same cycle; REDIR next cycle; no stall.
